// File: rtl/alu_reg_file.sv
// Eight-entry register file (entry 0 reads as zero) with a 1-cycle registered read,
// plus an independent combinational ALU. Reset asserts asynchronously, releases synchronously.
module alu_reg_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rw,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_data_in,
  output logic [DATA_W-1:0] reg_data_out,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_result
);

  localparam int NREG = 2 ** ADDR_W;

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] r_data_out;
  logic              w_lt;

  // Assert passes straight through; deassert reaches the datapath two edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (rw && (reg_addr != '0)) begin
      r_regs[reg_addr] <= reg_data_in;
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_data_out <= '0;
    end else if (!rw) begin
      r_data_out <= (reg_addr == '0) ? '0 : r_regs[reg_addr];
    end
  end

  assign reg_data_out = r_data_out;

  assign w_lt = ($signed(alu_a) < $signed(alu_b));

  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a & alu_b;
      4'd3:    alu_result = alu_a | alu_b;
      4'd4:    alu_result = {{(DATA_W-1){1'b0}}, w_lt};
      default: alu_result = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_reg_file.sv
// Directed bench for alu_reg_file: register write/read sweep, zero register,
// ALU sweep and hand-picked cases, and reset behaviour.
module tb_alu_reg_file;

  logic       clk;
  logic       rst_n;
  logic       rw;
  logic [2:0] reg_addr;
  logic [7:0] reg_data_in;
  logic [7:0] reg_data_out;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_result;

  int total = 0;
  int bad   = 0;

  alu_reg_file #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rw           (rw),
    .reg_addr     (reg_addr),
    .reg_data_in  (reg_data_in),
    .reg_data_out (reg_data_out),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one edge with the given command; inputs settle 1 time unit after the edge.
  task automatic do_edge(input logic w, input logic [2:0] a, input logic [7:0] d);
    rw = w; reg_addr = a; reg_data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rw = 1'b0; reg_addr = 3'd0; reg_data_in = 8'h00;
    alu_a = 8'h00; alu_b = 8'h00; alu_op = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (reg_data_out !== 8'h00) begin
      bad++; $display("FAIL reset_out actual=%h required=00", reg_data_out);
    end
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_edge(1'b0, 3'd5, 8'h00);
    total++;
    if (reg_data_out !== 8'h00) begin
      bad++; $display("FAIL reset_read5 actual=%h required=00", reg_data_out);
    end
  endtask

  task automatic test_write_read;
    logic [7:0] prev;
    do_edge(1'b1, 3'd2, 8'h3C);
    do_edge(1'b0, 3'd2, 8'h00);
    prev = 8'h3C;
    total++;
    if (reg_data_out !== prev) begin
      bad++; $display("FAIL rd_first actual=%h required=%h", reg_data_out, prev);
    end
    for (int a = 1; a < 8; a++) begin
      for (int v = 0; v < 256; v++) begin
        do_edge(1'b1, a[2:0], v[7:0]);
        total++;
        if (reg_data_out !== prev) begin
          bad++; $display("FAIL wr_hold addr=%0d actual=%h required=%h", a, reg_data_out, prev);
        end
        do_edge(1'b0, a[2:0], 8'h00);
        total++;
        if (reg_data_out !== v[7:0]) begin
          bad++; $display("FAIL wr_rd addr=%0d actual=%h required=%h", a, reg_data_out, v[7:0]);
        end
        prev = v[7:0];
      end
    end
  endtask

  task automatic test_zero_reg;
    do_edge(1'b1, 3'd0, 8'hAA);
    do_edge(1'b0, 3'd0, 8'h00);
    total++;
    if (reg_data_out !== 8'h00) begin
      bad++; $display("FAIL zero_reg actual=%h required=00", reg_data_out);
    end
  endtask

  task automatic test_back_to_back;
    do_edge(1'b1, 3'd1, 8'h11);
    do_edge(1'b1, 3'd6, 8'h66);
    do_edge(1'b1, 3'd7, 8'hE7);
    do_edge(1'b0, 3'd1, 8'h00);
    total++;
    if (reg_data_out !== 8'h11) begin
      bad++; $display("FAIL b2b_r1 actual=%h required=11", reg_data_out);
    end
    do_edge(1'b0, 3'd6, 8'h00);
    total++;
    if (reg_data_out !== 8'h66) begin
      bad++; $display("FAIL b2b_r6 actual=%h required=66", reg_data_out);
    end
    do_edge(1'b0, 3'd7, 8'h00);
    total++;
    if (reg_data_out !== 8'hE7) begin
      bad++; $display("FAIL b2b_r7 actual=%h required=e7", reg_data_out);
    end
    do_edge(1'b0, 3'd4, 8'h00);
    total++;
    if (reg_data_out !== 8'hFF) begin
      bad++; $display("FAIL b2b_r4 actual=%h required=ff", reg_data_out);
    end
  endtask

  task automatic test_alu_sweep;
    logic [7:0] exp;
    for (int op = 0; op < 4; op++) begin
      for (int a = 0; a < 256; a++) begin
        for (int b = 0; b < 256; b++) begin
          alu_op = op[3:0]; alu_a = a[7:0]; alu_b = b[7:0];
          #1;
          case (op)
            0:       exp = 8'((a + b) % 256);
            1:       exp = 8'((a - b + 256) % 256);
            2:       exp = a[7:0] & b[7:0];
            default: exp = a[7:0] | b[7:0];
          endcase
          total++;
          if (alu_result !== exp) begin
            bad++;
            $display("FAIL alu_sweep op=%0d a=%h b=%h actual=%h required=%h", op, a[7:0], b[7:0], alu_result, exp);
          end
        end
      end
    end
  endtask

  task automatic test_alu_cases;
    logic [3:0] ops [8];
    logic [7:0] as  [8];
    logic [7:0] bs  [8];
    logic [7:0] exs [8];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4};
    as  = '{8'd200, 8'd5, 8'hF0, 8'hF0, 8'hFF, 8'h01, 8'h80, 8'h42};
    bs  = '{8'd100, 8'd10, 8'h3C, 8'h0F, 8'h01, 8'hFF, 8'h7F, 8'h42};
    exs = '{8'd44, 8'd251, 8'h30, 8'hFF, 8'h01, 8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 8; i++) begin
      alu_op = ops[i]; alu_a = as[i]; alu_b = bs[i];
      #1;
      total++;
      if (alu_result !== exs[i]) begin
        bad++; $display("FAIL alu_case%0d actual=%h required=%h", i, alu_result, exs[i]);
      end
    end
    for (int op = 5; op < 16; op++) begin
      alu_op = op[3:0]; alu_a = 8'hFF; alu_b = 8'hFF;
      #1;
      total++;
      if (alu_result !== 8'h00) begin
        bad++; $display("FAIL alu_unused op=%0d actual=%h required=00", op, alu_result);
      end
    end
  endtask

  task automatic test_mid_reset;
    do_edge(1'b1, 3'd3, 8'h5A);
    do_edge(1'b0, 3'd3, 8'h00);
    total++;
    if (reg_data_out !== 8'h5A) begin
      bad++; $display("FAIL mrst_pre actual=%h required=5a", reg_data_out);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (reg_data_out !== 8'h00) begin
      bad++; $display("FAIL mrst_immediate actual=%h required=00", reg_data_out);
    end
    alu_op = 4'd0; alu_a = 8'd3; alu_b = 8'd4;
    #1;
    total++;
    if (alu_result !== 8'd7) begin
      bad++; $display("FAIL mrst_alu actual=%h required=07", alu_result);
    end
    @(posedge clk); #1;
    do_edge(1'b1, 3'd3, 8'h77);
    total++;
    if (reg_data_out !== 8'h00) begin
      bad++; $display("FAIL mrst_hold actual=%h required=00", reg_data_out);
    end
    #2 rst_n = 1'b1;
    rw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_edge(1'b0, 3'd3, 8'h00);
    total++;
    if (reg_data_out !== 8'h00) begin
      bad++; $display("FAIL mrst_read3 actual=%h required=00", reg_data_out);
    end
    do_edge(1'b0, 3'd7, 8'h00);
    total++;
    if (reg_data_out !== 8'h00) begin
      bad++; $display("FAIL mrst_read7 actual=%h required=00", reg_data_out);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_zero_reg;
    test_back_to_back;
    test_alu_cases;
    test_mid_reset;
    test_alu_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
